// File: rtl/audio_pkg.sv
// Shared types and widths for the tone sequencer: FSM state encoding,
// note field widths and the default millisecond prescale.
package audio_pkg;

    localparam int HP_W                 = 20;
    localparam int DUR_W                = 12;
    localparam int ENTRY_W              = HP_W + DUR_W;
    localparam int LEVEL_W              = 4;
    localparam int TICKS_PER_MS_DEFAULT = 25000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/tone_sequencer_if.sv
// Note-entry channel between a host (master) and the tone sequencer (slave).
// A note transfers on a rising edge where note_valid && note_ready; note_ready never depends on note_valid.
interface tone_sequencer_if;
    import audio_pkg::*;

    logic             note_valid;
    logic             note_ready;
    logic [HP_W-1:0]  note_half_period;
    logic [DUR_W-1:0] note_duration;

    modport master (
        output note_valid,
        output note_half_period,
        output note_duration,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_half_period,
        input  note_duration,
        output note_ready
    );

endinterface

// File: rtl/note_fifo.sv
// Power-of-two note queue with occupancy count and a synchronous flush.
// The caller guarantees no push when full and no pop when empty.
module note_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [W-1:0]           i_data,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/tone_sequencer.sv
// Plays queued square-wave notes: each entry is a half-period (0 = rest) and a
// duration in ms, followed by a fixed silent gap and a one-cycle note_done pulse.
module tone_sequencer
    import audio_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int TICKS_PER_MS = TICKS_PER_MS_DEFAULT,
    parameter int GAP_MS       = 5
) (
    input  logic               clk_25mhz,
    input  logic               resetn,
    tone_sequencer_if.slave    note_if,
    input  logic               abort,
    output logic               audio,
    output logic               busy,
    output logic               note_done,
    output logic [LEVEL_W-1:0] level,
    output state_t             dbg_state
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICKS_PER_MS - 1);
    localparam logic [DUR_W-1:0] GAP_LD   = DUR_W'(GAP_MS);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;
    logic               w_empty;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_busy;
    logic               w_gap_end;
    logic               w_wrap;
    logic               w_ms_last;
    logic [HP_W-1:0]    r_hp;
    logic [HP_W-1:0]    r_hp_cnt;
    logic [DUR_W-1:0]   r_dur;
    logic [DUR_W-1:0]   r_ms;
    logic [PRE_W-1:0]   r_pre;
    logic               r_audio;
    logic               r_note_done;

    // Reset asserts asynchronously everywhere but releases two edges later.
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    note_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk_25mhz),
        .rst_n   (w_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (abort),
        .i_data  ({note_if.note_half_period, note_if.note_duration}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    // One ms counter serves both PLAY and GAP; a zero count ends GAP at once.
    assign w_wrap    = (r_pre == '0);
    assign w_ms_last = (r_ms == '0) || (w_wrap && (r_ms == DUR_W'(1)));

    always_ff @(posedge clk_25mhz or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (!w_empty) w_next = LOAD;
                LOAD:    w_next = (r_dur == '0) ? GAP : PLAY;
                PLAY:    if (w_ms_last) w_next = GAP;
                GAP:     if (w_ms_last) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_empty   = (w_count == '0);
        w_ready   = (w_count < FULL_CNT) && !abort;
        w_push    = note_if.note_valid && w_ready;
        w_pop     = (r_state == IDLE) && !w_empty && !abort;
        w_busy    = (r_state != IDLE) || !w_empty;
        w_gap_end = (r_state == GAP) && w_ms_last && !abort;
    end

    always_ff @(posedge clk_25mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hp        <= '0;
            r_dur       <= '0;
            r_hp_cnt    <= '0;
            r_ms        <= '0;
            r_pre       <= '0;
            r_audio     <= 1'b0;
            r_note_done <= 1'b0;
        end else begin
            r_note_done <= w_gap_end;
            if (abort) begin
                r_audio <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // The head is captured at pop time because the read pointer moves on.
                        if (w_pop) begin
                            r_hp  <= w_head[ENTRY_W-1 -: HP_W];
                            r_dur <= w_head[DUR_W-1:0];
                        end
                    end
                    LOAD: begin
                        r_audio  <= 1'b0;
                        r_hp_cnt <= (r_hp == '0) ? '0 : r_hp - 1'b1;
                        r_pre    <= PRE_MAX;
                        r_ms     <= (r_dur == '0) ? GAP_LD : r_dur;
                    end
                    PLAY: begin
                        r_pre <= w_wrap ? PRE_MAX : r_pre - 1'b1;
                        if (w_ms_last) begin
                            r_audio <= 1'b0;
                            r_ms    <= GAP_LD;
                        end else begin
                            if (w_wrap) r_ms <= r_ms - 1'b1;
                            if (r_hp != '0) begin
                                if (r_hp_cnt == '0) begin
                                    r_audio  <= ~r_audio;
                                    r_hp_cnt <= r_hp - 1'b1;
                                end else begin
                                    r_hp_cnt <= r_hp_cnt - 1'b1;
                                end
                            end
                        end
                    end
                    GAP: begin
                        r_audio <= 1'b0;
                        r_pre   <= w_wrap ? PRE_MAX : r_pre - 1'b1;
                        if (w_wrap && !w_ms_last) r_ms <= r_ms - 1'b1;
                    end
                    default: r_audio <= 1'b0;
                endcase
            end
        end
    end

    assign note_if.note_ready = w_ready;
    assign audio              = r_audio;
    assign busy               = w_busy;
    assign note_done          = r_note_done;
    assign level              = LEVEL_W'(w_count);
    assign dbg_state          = r_state;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICKS_PER_MS = 10 and GAP_MS = 1;
// expected cycle positions are counted from the push edge (E1).
module tb_tone_sequencer;
    import audio_pkg::*;

    logic         clk_25mhz = 1'b0;
    logic         resetn;
    logic         abort;
    logic         audio;
    logic         busy;
    logic         note_done;
    logic [3:0]   level;
    state_t       dbg_state;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           tog_cnt = 0;
    int           nd_cnt  = 0;
    int           waited;
    logic         prev_audio = 1'b0;

    tone_sequencer_if nif ();

    tone_sequencer #(
        .DEPTH        (8),
        .TICKS_PER_MS (10),
        .GAP_MS       (1)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .resetn    (resetn),
        .note_if   (nif.slave),
        .abort     (abort),
        .audio     (audio),
        .busy      (busy),
        .note_done (note_done),
        .level     (level),
        .dbg_state (dbg_state)
    );

    always #5 clk_25mhz = ~clk_25mhz;

    // Counts audio transitions and note_done cycles between clear_mon calls.
    always @(negedge clk_25mhz) begin
        if (audio !== prev_audio) tog_cnt++;
        prev_audio = audio;
        if (note_done === 1'b1) nd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_25mhz);
        #1;
    endtask

    task automatic offer(input logic [19:0] hp, input logic [11:0] dur);
        nif.note_valid       = 1'b1;
        nif.note_half_period = hp;
        nif.note_duration    = dur;
    endtask

    task automatic clear_mon();
        tog_cnt    = 0;
        nd_cnt     = 0;
        prev_audio = audio;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn               = 1'b1;
        abort                = 1'b0;
        nif.note_valid       = 1'b0;
        nif.note_half_period = '0;
        nif.note_duration    = '0;
        #2 resetn = 1'b0;
        #2;
        check("rst_audio", 32'(audio), 0);
        check("rst_level", 32'(level), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(note_done), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        repeat (3) @(posedge clk_25mhz);
        #3 resetn = 1'b1;
        step(4);
        check("rst_ready", 32'(nif.note_ready), 1);
        clear_mon();

        // Tone hp=3 dur=2: PLAY E3..E23, GAP E23..E33, note_done after E33
        offer(20'd3, 12'd2);
        check("t1_ready", 32'(nif.note_ready), 1);
        step(1);
        nif.note_valid = 1'b0;
        check("t1_level_push", 32'(level), 1);
        check("t1_busy_queued", 32'(busy), 1);
        step(1);
        check("t1_state_load", 32'(dbg_state), 32'(LOAD));
        check("t1_level_pop", 32'(level), 0);
        step(1);
        check("t1_state_play", 32'(dbg_state), 32'(PLAY));
        step(2);
        check("t1_audio_e5", 32'(audio), 0);
        step(1);
        check("t1_audio_e6", 32'(audio), 1);
        step(3);
        check("t1_audio_e9", 32'(audio), 0);
        step(13);
        check("t1_state_e22", 32'(dbg_state), 32'(PLAY));
        step(1);
        check("t1_state_gap", 32'(dbg_state), 32'(GAP));
        check("t1_audio_gap", 32'(audio), 0);
        step(9);
        check("t1_done_early", 32'(note_done), 0);
        step(1);
        check("t1_done", 32'(note_done), 1);
        check("t1_state_idle", 32'(dbg_state), 32'(IDLE));
        check("t1_busy_end", 32'(busy), 0);
        step(1);
        check("t1_done_pulse", 32'(note_done), 0);
        check("t1_toggles", 32'(tog_cnt), 6);
        check("t1_done_count", 32'(nd_cnt), 1);
        check("t1_level_end", 32'(level), 0);

        // Fill: one note playing, then 9 offers -> 8 accepted, ready low until pop at E34
        offer(20'd2, 12'd2);
        step(1);
        nif.note_valid = 1'b0;
        step(2);
        check("fill_state_play", 32'(dbg_state), 32'(PLAY));
        for (int i = 0; i < 9; i++) begin
            offer(20'(i + 1), 12'd1);
            check("fill_ready", 32'(nif.note_ready), 32'(i < 8));
            step(1);
        end
        nif.note_valid = 1'b0;
        check("fill_level_full", 32'(level), 8);
        check("fill_ready_full", 32'(nif.note_ready), 0);
        waited = 0;
        for (int k = 0; k < 60; k++) begin
            if (nif.note_ready) break;
            step(1);
            waited++;
        end
        check("fill_wait_pop", 32'(waited), 22);
        check("fill_level_pop", 32'(level), 7);
        check("fill_state_load", 32'(dbg_state), 32'(LOAD));
        abort = 1'b1;
        offer(20'd7, 12'd7);
        #1;
        check("fill_abort_ready", 32'(nif.note_ready), 0);
        step(1);
        abort          = 1'b0;
        nif.note_valid = 1'b0;
        check("fill_abort_level", 32'(level), 0);
        check("fill_abort_state", 32'(dbg_state), 32'(IDLE));
        check("fill_abort_busy", 32'(busy), 0);

        // Rest hp=0 dur=1: PLAY E3..E13, GAP E13..E23, audio silent
        clear_mon();
        offer(20'd0, 12'd1);
        step(1);
        nif.note_valid = 1'b0;
        step(2);
        check("rest_state_play", 32'(dbg_state), 32'(PLAY));
        step(10);
        check("rest_state_gap", 32'(dbg_state), 32'(GAP));
        step(9);
        check("rest_done_early", 32'(note_done), 0);
        step(1);
        check("rest_done", 32'(note_done), 1);
        step(1);
        check("rest_toggles", 32'(tog_cnt), 0);
        check("rest_done_count", 32'(nd_cnt), 1);

        // Zero duration: LOAD E2, GAP E3..E13, note_done after E13
        clear_mon();
        offer(20'd5, 12'd0);
        step(1);
        nif.note_valid = 1'b0;
        step(1);
        check("zd_state_load", 32'(dbg_state), 32'(LOAD));
        step(1);
        check("zd_state_gap", 32'(dbg_state), 32'(GAP));
        step(9);
        check("zd_done_early", 32'(note_done), 0);
        step(1);
        check("zd_done", 32'(note_done), 1);
        step(1);
        check("zd_toggles", 32'(tog_cnt), 0);
        check("zd_done_count", 32'(nd_cnt), 1);

        // Abort mid-PLAY with 3 queued entries
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            offer(20'd2, 12'd3);
            step(1);
        end
        nif.note_valid = 1'b0;
        check("ab_level_before", 32'(level), 3);
        step(1);
        check("ab_audio_high", 32'(audio), 1);
        check("ab_state_play", 32'(dbg_state), 32'(PLAY));
        abort = 1'b1;
        offer(20'd9, 12'd9);
        step(1);
        abort          = 1'b0;
        nif.note_valid = 1'b0;
        check("ab_audio", 32'(audio), 0);
        check("ab_level", 32'(level), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_state", 32'(dbg_state), 32'(IDLE));
        check("ab_done", 32'(note_done), 0);
        step(40);
        check("ab_no_done", 32'(nd_cnt), 0);
        check("ab_busy_later", 32'(busy), 0);

        // Reset mid-GAP with one entry still queued
        clear_mon();
        offer(20'd2, 12'd1);
        step(1);
        step(1);
        nif.note_valid = 1'b0;
        step(13);
        check("mr_state_gap", 32'(dbg_state), 32'(GAP));
        check("mr_level_before", 32'(level), 1);
        check("mr_busy_before", 32'(busy), 1);
        #2 resetn = 1'b0;
        #1;
        check("mr_audio", 32'(audio), 0);
        check("mr_level", 32'(level), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_done", 32'(note_done), 0);
        check("mr_state", 32'(dbg_state), 32'(IDLE));
        repeat (2) @(posedge clk_25mhz);
        #3 resetn = 1'b1;
        step(4);
        check("mr_rel_state", 32'(dbg_state), 32'(IDLE));
        check("mr_rel_level", 32'(level), 0);
        check("mr_rel_busy", 32'(busy), 0);
        check("mr_rel_ready", 32'(nif.note_ready), 1);
        step(20);
        check("mr_no_done", 32'(nd_cnt), 0);
        offer(20'd0, 12'd0);
        step(1);
        nif.note_valid = 1'b0;
        step(12);
        check("mr_after_done", 32'(note_done), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
